multicycle_alu: RTL and testbench
=================================

Name: multicycle_alu

Overview:
Parametrised successor to the processor's 16-bit registered ALU. It keeps the A/B operand registers, the ALUout register, the ALUop/Func decode and the isNegative/overflow/isZero flags. It generalises the datapath width and adds shift (sll/srl/sra) and multiply operations, which execute iteratively under a start/busy/done handshake. It sits between the register-file read ports and the ALUout/writeback path, and the control FSM stalls on busy.

Parameters:
WIDTH, 16, datapath width in bits; must be >= 4 and a power of two.
SHW, $clog2(WIDTH), width of the shift-amount field taken from B[SHW-1:0].

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
A  input  WIDTH  operand A, captured into A_reg.
B  input  WIDTH  operand B, captured into B_reg.
A_write  input  1  A_reg load enable.
B_write  input  1  B_reg load enable.
ALUout_write  input  1  ALUout load enable for single-cycle ops.
ALUop  input  2  0=add, 1=sub, 2=use Func, 3=or.
Func  input  4  0 add, 1 sub, 2 and, 3 or, 4 nor, 5 nand, 6 xor, 7 slt, 8 sll, 9 srl, 10 sra, 11 mul, 12-15 reserved.
start  input  1  launches a multicycle op (Func 8-11 with ALUop=2).
busy  output  1  high while a multicycle op is in progress.
done  output  1  one-cycle pulse on the edge ALUout takes a multicycle result.
Result  output  WIDTH  ALUout register.
isNegative  output  1  Result[WIDTH-1].
overflow  output  1  registered overflow flag.
isZero  output  1  Result == 0.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - A_reg, B_reg, Result, overflow, the iteration counter and the accumulator clear to 0.
  - FSM goes to IDLE; busy=0, done=0.
  - Consequently isZero=1 and isNegative=0.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - A_reg/B_reg load on enable.
  - If ALUout_write=1, Result and overflow load from the combinational op on the current A_reg/B_reg/ALUop/Func.
  - Latency: operands written at edge N give Result at edge N+1 (with all enables held high).
- Single-cycle arithmetic:
  - add/sub: WIDTH-bit wrap-around.
  - overflow = signed overflow: add overflows when operands have the same sign and the result differs; sub overflows when operands have different signs and the result sign differs from A.
  - slt: Result = 1 if signed A_reg < B_reg, using the true sign (sub_msb XOR sub_overflow), else 0; overflow = the subtraction's signed overflow.
  - Logic ops: overflow = 0.
  - Reserved Func codes: Result = 0, overflow = 0.
  - Multicycle Func codes without start: Result and overflow are held.
- IDLE & start & multicycle op:
  - Capture the op, A_reg and B_reg into working registers; go to RUN; busy=1 from the next cycle.
  - In the same cycle, start has priority over ALUout_write.
- start with a single-cycle op: ignored.
- RUN, shifts:
  - One bit per cycle for shamt = B[SHW-1:0] cycles.
  - shamt = 0 goes directly to FINISH after one RUN cycle.
  - sra replicates the sign bit; srl/sll shift in 0.
  - overflow = 0.
- RUN, mul:
  - Unsigned shift-add over exactly WIDTH cycles.
  - Result = low WIDTH bits of the product.
  - overflow = 1 if any of the high WIDTH bits of the product are nonzero.
- FINISH:
  - Result and overflow load unconditionally, independent of ALUout_write.
  - done=1 for exactly this edge; busy drops together with done.
  - Return to IDLE.
- While busy: A_write, B_write, ALUout_write and start are ignored. Operand inputs changing mid-operation have no effect.
- Total multicycle latency from the start edge:
  - Shifts: max(shamt,1) + 1 cycles.
  - mul: WIDTH + 1 cycles.
- Back-to-back operation: start asserted on the cycle after done is accepted (the FSM is back in IDLE).

Test Plan:
- Reset asserted asynchronously mid-mul (cycle 5) -> busy=0, done=0, Result=0, isZero=1 with no clock edge required; the next op runs normally.
- ALUop=0, A=0x4000, B=0x4000, enables=1 -> next edge Result=0x8000, overflow=1, isNegative=1. Then ALUop=1 with A=4, B=4 -> isZero=1.
- ALUop=2, Func=7: A=0x8000, B=0x0001 -> Result=1. Then A=0x4000, B=0xC000 -> Result=0, overflow=1.
- Func=10 (sra), A=0x8F00, B=4, start -> busy for 4 RUN cycles, done at cycle 5 (counted from the start edge), Result=0xF8F0; A_write pulsed while busy leaves A_reg unchanged.
- Func=11 (mul), A=300, B=300, start -> done at cycle WIDTH+1 (=17), Result=0x5F90, overflow=1. Then A=7, B=9 -> Result=63, overflow=0.
- WIDTH=32 instance: Func=8 (sll), A=1, B=31 -> Result=0x80000000, isNegative=1; B=0 -> Result=A after 2 cycles, done pulse of width 1.

Source files
------------

// File: rtl/multicycle_alu.sv
// Registered ALU with operand/result registers, single-cycle arithmetic and logic ops, and
// iterative shift and multiply ops run under a start/busy/done handshake.
module multicycle_alu #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             A_write,
  input  logic             B_write,
  input  logic             ALUout_write,
  input  logic [1:0]       ALUop,
  input  logic [3:0]       Func,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             isNegative,
  output logic             overflow,
  output logic             isZero
);

  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d, mcand_q, mcand_d;
  logic               ovf_q, ovf_d, done_q, done_d;
  logic [SHW:0]       cnt_q, cnt_d;
  logic [1:0]         mop_q, mop_d;
  // Shifts work in the low half; mul keeps {partial product, remaining multiplier bits}.
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic [3:0]       op;
  logic [WIDTH-1:0] sum, diff, comb_res;
  logic [WIDTH:0]   mul_sum;
  logic             add_ovf, sub_ovf, comb_ovf, is_multi;

  always_comb begin
    unique case (ALUop)
      2'd0:    op = 4'd0;
      2'd1:    op = 4'd1;
      2'd2:    op = Func;
      default: op = 4'd3;
    endcase
  end

  assign sum      = a_q + b_q;
  assign diff     = a_q - b_q;
  assign add_ovf  = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
  assign sub_ovf  = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
  assign is_multi = (op[3:2] == 2'b10);
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

  always_comb begin
    comb_res = '0;
    comb_ovf = 1'b0;
    unique case (op)
      4'd0: begin comb_res = sum;  comb_ovf = add_ovf; end
      4'd1: begin comb_res = diff; comb_ovf = sub_ovf; end
      4'd2: comb_res = a_q & b_q;
      4'd3: comb_res = a_q | b_q;
      4'd4: comb_res = ~(a_q | b_q);
      4'd5: comb_res = ~(a_q & b_q);
      4'd6: comb_res = a_q ^ b_q;
      4'd7: begin
        comb_res = {{(WIDTH-1){1'b0}}, diff[MSB] ^ sub_ovf};
        comb_ovf = sub_ovf;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mop_d    = mop_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (A_write) a_d = A;
        if (B_write) b_d = B;
        if (start && is_multi) begin
          mop_d   = op[1:0];
          mcand_d = a_q;
          state_d = StRun;
          if (op[1:0] == 2'd3) begin
            acc_d = {{WIDTH{1'b0}}, b_q};
            cnt_d = (SHW+1)'(WIDTH);
          end else begin
            acc_d = {{WIDTH{1'b0}}, a_q};
            cnt_d = {1'b0, b_q[SHW-1:0]};
          end
        end else if (ALUout_write && !is_multi) begin
          result_d = comb_res;
          ovf_d    = comb_ovf;
        end
      end
      StRun: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - (SHW+1)'(1);
          unique case (mop_q)
            2'd0: acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
            2'd1: acc_d = {acc_q[2*WIDTH-1:WIDTH], 1'b0, acc_q[WIDTH-1:1]};
            2'd2: acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[MSB], acc_q[WIDTH-1:1]};
            default: acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          endcase
        end
        // A zero shift amount still spends one cycle here.
        if (cnt_q <= (SHW+1)'(1)) state_d = StFinish;
      end
      StFinish: begin
        result_d = acc_q[WIDTH-1:0];
        ovf_d    = (mop_q == 2'd3) ? |acc_q[2*WIDTH-1:WIDTH] : 1'b0;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mop_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mop_q    <= mop_d;
      done_q   <= done_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign Result     = result_q;
  assign isNegative = result_q[MSB];
  assign isZero     = (result_q == '0);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomised and directed bench for multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 16-bit instance
  logic [15:0] a, b, res;
  logic a_wr, b_wr, alu_wr, start, busy, done, neg, ovf, zero;
  logic [1:0] aluop;
  logic [3:0] func;

  // 32-bit instance
  logic [31:0] a32, b32, res32;
  logic a_wr32, b_wr32, alu_wr32, start32, busy32, done32, neg32, ovf32, zero32;
  logic [1:0] aluop32;
  logic [3:0] func32;

  multicycle_alu #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .A(a), .B(b), .A_write(a_wr), .B_write(b_wr),
    .ALUout_write(alu_wr), .ALUop(aluop), .Func(func), .start(start), .busy(busy),
    .done(done), .Result(res), .isNegative(neg), .overflow(ovf), .isZero(zero)
  );

  multicycle_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .A(a32), .B(b32), .A_write(a_wr32), .B_write(b_wr32),
    .ALUout_write(alu_wr32), .ALUop(aluop32), .Func(func32), .start(start32), .busy(busy32),
    .done(done32), .Result(res32), .isNegative(neg32), .overflow(ovf32), .isZero(zero32)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (16-bit) ----------------
  int m_a = 0, m_b = 0, m_res = 0, m_pres = 0, m_left = 0;
  bit m_ovf = 0, m_povf = 0, m_busy = 0, m_done = 0;
  int m_code, m_r;
  bit m_o;

  function automatic int sx(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic bit out_of_range(input int t);
    return (t > 32767) || (t < -32768);
  endfunction

  task automatic op_eval(input int x, input int y, input int code, output int r, output bit o);
    int sa, sb, sh;
    longint p;
    sa = sx(x);
    sb = sx(y);
    sh = y % 16;
    r = 0;
    o = 1'b0;
    case (code)
      0:  begin r = (x + y) & 'hFFFF; o = out_of_range(sa + sb); end
      1:  begin r = (x - y) & 'hFFFF; o = out_of_range(sa - sb); end
      2:  r = x & y;
      3:  r = x | y;
      4:  r = (~(x | y)) & 'hFFFF;
      5:  r = (~(x & y)) & 'hFFFF;
      6:  r = x ^ y;
      7:  begin r = (sa < sb) ? 1 : 0; o = out_of_range(sa - sb); end
      8:  r = (x << sh) & 'hFFFF;
      9:  r = x >> sh;
      10: r = (sa >>> sh) & 'hFFFF;
      11: begin p = longint'(x) * longint'(y); r = int'(p & 'hFFFF); o = (p >> 16) != 0; end
      default: ;
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_a = 0; m_b = 0; m_res = 0; m_ovf = 0; m_busy = 0; m_done = 0; m_left = 0;
    end else begin
      m_done = 0;
      m_code = (aluop == 2'd2) ? int'(func) : ((aluop == 2'd3) ? 3 : int'(aluop));
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_res = m_pres; m_ovf = m_povf; m_busy = 0; m_done = 1;
        end
      end else begin
        if (start && m_code >= 8 && m_code <= 11) begin
          op_eval(m_a, m_b, m_code, m_pres, m_povf);
          m_left = (m_code == 11) ? 17 : (((m_b % 16) == 0) ? 1 : (m_b % 16)) + 1;
          m_busy = 1;
        end else if (alu_wr && !(m_code >= 8 && m_code <= 11)) begin
          op_eval(m_a, m_b, m_code, m_r, m_o);
          m_res = m_r; m_ovf = m_o;
        end
        if (a_wr) m_a = int'(a);
        if (b_wr) m_b = int'(b);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("Result", res, m_res);
      chk("overflow", ovf, m_ovf);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("isZero", zero, m_res == 0);
      chk("isNegative", neg, m_res >= 32768);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait16(output int k);
    k = 0;
    do begin tick(); k++; end while (!done && k < 60);
  endtask

  task automatic wait32(output int k);
    k = 0;
    do begin tick(); k++; end while (!done32 && k < 60);
  endtask

  task automatic set16(input int av, input int bv, input int op, input int fn);
    a = 16'(av); b = 16'(bv); aluop = 2'(op); func = 4'(fn);
  endtask

  int k;

  initial begin
    reset = 1'b1;
    {a, b, a_wr, b_wr, alu_wr, start, aluop, func} = '0;
    {a32, b32, a_wr32, b_wr32, alu_wr32, start32, aluop32, func32} = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_result", res, 0);
    chk("reset_isZero", zero, 1);

    // add overflow, then sub to zero
    a_wr = 1; b_wr = 1; alu_wr = 1;
    set16('h4000, 'h4000, 0, 0); tick(); tick();
    chk("add_res", res, 'h8000); chk("add_ovf", ovf, 1); chk("add_neg", neg, 1);
    chk("model_add", m_res, 'h8000);
    set16(4, 4, 1, 0); tick(); tick();
    chk("sub_zero", zero, 1);

    // slt
    set16('h8000, 1, 2, 7); tick(); tick();
    chk("slt_neg", res, 1); chk("model_slt", m_res, 1);
    set16('h4000, 'hC000, 2, 7); tick(); tick();
    chk("slt_res", res, 0); chk("slt_ovf", ovf, 1);

    // sra with A_write pulsed while busy
    alu_wr = 0;
    set16('h8F00, 4, 2, 10); tick();
    start = 1; a_wr = 0; b_wr = 0; tick();
    start = 0; a = 16'h1234; a_wr = 1;
    wait16(k);
    a_wr = 0;
    chk("sra_latency", k, 5); chk("sra_res", res, 'hF8F0); chk("model_sra", m_res, 'hF8F0);
    aluop = 2'd3; alu_wr = 1; tick();
    chk("done_width", done, 0); chk("a_held", res, 'h8F04);

    // mul
    alu_wr = 0; a_wr = 1; b_wr = 1;
    set16(300, 300, 2, 11); tick();
    start = 1; a_wr = 0; b_wr = 0; tick(); start = 0;
    wait16(k);
    chk("mul_latency", k, 17); chk("mul_res", res, 'h5F90); chk("mul_ovf", ovf, 1);
    chk("model_mul", m_res, 'h5F90);
    a_wr = 1; b_wr = 1; set16(7, 9, 2, 11); tick();
    start = 1; a_wr = 0; b_wr = 0; tick(); start = 0;
    wait16(k);
    chk("mul_small", res, 63); chk("mul_small_ovf", ovf, 0);

    // asynchronous reset mid-mul
    start = 1; tick(); start = 0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0); chk("arst_done", done, 0);
    chk("arst_res", res, 0); chk("arst_zero", zero, 1);
    tick();
    reset = 1'b0;
    a_wr = 1; b_wr = 1; set16(7, 9, 2, 11); tick();
    start = 1; a_wr = 0; b_wr = 0; tick(); start = 0;
    wait16(k);
    chk("post_rst_latency", k, 17); chk("post_rst_res", res, 63);

    // 32-bit instance: sll
    a32 = 32'd1; b32 = 32'd31; a_wr32 = 1; b_wr32 = 1; aluop32 = 2'd2; func32 = 4'd8; tick();
    start32 = 1; a_wr32 = 0; b_wr32 = 0; tick(); start32 = 0;
    wait32(k);
    chk("sll32_latency", k, 32); chk("sll32_res", res32, 32'h8000_0000);
    chk("sll32_neg", neg32, 1);
    b32 = 32'd0; b_wr32 = 1; tick();
    b_wr32 = 0; start32 = 1; tick(); start32 = 0;
    wait32(k);
    chk("sll32_zero_latency", k, 2); chk("sll32_zero_res", res32, 1);
    tick();
    chk("done32_width", done32, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      aluop = 2'($urandom); func = 4'($urandom);
      a_wr = 1'($urandom); b_wr = 1'($urandom); alu_wr = 1'($urandom);
      start = ($urandom_range(0, 3) == 0);
      tick();
    end
    {a_wr, b_wr, alu_wr, start} = '0;
    repeat (20) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
